// File: rtl/level_meter.sv
// level_meter: peak-reading level meter with hold/decay peak, 8-segment
// dBFS bar-graph and held clip indicator. Optional clip event counter is
// enabled by defining LEVEL_METER_CLIPCOUNT_EN.
module level_meter #(
  parameter int HOLD_SAMPLES      = 24000,
  parameter int DECAY_STEP        = 2,
  parameter int CLIP_HOLD_SAMPLES = 48000
) (
  input  logic               clk_48,
  input  logic               reset,
  input  logic signed [15:0] meterIn,
  output logic        [15:0] peakLevel,
  output logic         [7:0] meterLeds,
`ifdef LEVEL_METER_CLIPCOUNT_EN
  output logic         [7:0] clipCount,
`endif
  output logic               clip
);

  localparam int HW = $clog2(HOLD_SAMPLES + 1);
  localparam int CW = $clog2(CLIP_HOLD_SAMPLES + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_SAMPLES - 1);
  localparam logic [CW-1:0] CLIP_INIT = CW'(CLIP_HOLD_SAMPLES - 1);
  localparam logic [15:0]   STEP      = 16'(DECAY_STEP);
  localparam logic [15:0]   FULL      = 16'h7FFF;

  // Segment thresholds, index 0 is the lowest LED (-42 dBFS .. -1 dBFS)
  localparam logic [7:0][15:0] THR = {16'd29204, 16'd16423, 16'd8231, 16'd4125,
                                      16'd2068,  16'd1036,  16'd519,  16'd260};

  typedef enum logic [1:0] {IDLE, HOLD, DECAY} state_t;

  state_t        state, state_nxt;
  logic [15:0]   mag, neg, dec, peak_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [CW-1:0] clip_cnt;
  logic [7:0]    leds_nxt;
  logic          clip_det;

  // Two's-complement negate; -32768 has no positive twin so it saturates
  assign neg      = ~meterIn + 16'd1;
  assign mag      = (meterIn == 16'sh8000) ? FULL : (meterIn[15] ? neg : meterIn);
  assign clip_det = (mag == FULL);
  // Decay floors at zero rather than wrapping
  assign dec      = (peakLevel > STEP) ? (peakLevel - STEP) : 16'd0;

  // Thermometer compare, one comparator per segment
  for (genvar g = 0; g < 8; g++) begin : g_seg
    assign leds_nxt[g] = (peakLevel >= THR[g]);
  end

  // Peak FSM next-state: capture wins over every other transition
  always_comb begin
    state_nxt = state;
    peak_nxt  = peakLevel;
    hold_nxt  = hold_cnt;
    if (mag >= peakLevel && mag != 16'd0) begin
      peak_nxt  = mag;
      hold_nxt  = HOLD_INIT;
      state_nxt = HOLD;
    end else begin
      case (state)
        IDLE:  state_nxt = IDLE;
        HOLD: begin
          if (hold_cnt == '0) state_nxt = DECAY;
          else                hold_nxt  = hold_cnt - HW'(1);
        end
        DECAY: begin
          peak_nxt = (dec > mag) ? dec : mag;
          if (peak_nxt == 16'd0) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Peak FSM state, peak and hold counter registers
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      peakLevel <= 16'd0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      peakLevel <= peak_nxt;
      hold_cnt  <= hold_nxt;
    end
  end

  // Bar-graph registered from the current peak, one cycle behind it
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) meterLeds <= 8'd0;
    else       meterLeds <= leds_nxt;
  end

  // Clip flag with retriggerable hold counter
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      clip     <= 1'b0;
      clip_cnt <= '0;
    end else if (clip_det) begin
      clip     <= 1'b1;
      clip_cnt <= CLIP_INIT;
    end else if (clip_cnt != '0) begin
      clip_cnt <= clip_cnt - CW'(1);
    end else begin
      clip <= 1'b0;
    end
  end

`ifdef LEVEL_METER_CLIPCOUNT_EN
  logic clip_det_q;

  // Count rising edges of clip detection, saturating at 255
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      clip_det_q <= 1'b0;
      clipCount  <= 8'd0;
    end else begin
      clip_det_q <= clip_det;
      if (clip_det && !clip_det_q && clipCount != 8'hFF)
        clipCount <= clipCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_level_meter.sv
// tb_level_meter: directed self-checking bench for level_meter with short
// hold/decay/clip parameters; clipCount checks when the macro is defined.
module tb_level_meter;

  logic               clk_48 = 1'b0;
  logic               reset;
  logic signed [15:0] meterIn;
  logic        [15:0] peakLevel;
  logic         [7:0] meterLeds;
  logic               clip;
`ifdef LEVEL_METER_CLIPCOUNT_EN
  logic         [7:0] clipCount;
`endif

  int checks   = 0;
  int failures = 0;

  level_meter #(.HOLD_SAMPLES(8), .DECAY_STEP(1000), .CLIP_HOLD_SAMPLES(4)) dut (
    .clk_48    (clk_48),
    .reset     (reset),
    .meterIn   (meterIn),
    .peakLevel (peakLevel),
    .meterLeds (meterLeds),
`ifdef LEVEL_METER_CLIPCOUNT_EN
    .clipCount (clipCount),
`endif
    .clip      (clip)
  );

  always #5 clk_48 = ~clk_48;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one sample, let it be taken on the next edge, sample after it
  task automatic step(input logic [15:0] x);
    meterIn = x;
    @(posedge clk_48);
    #1;
  endtask

  // Pulse async reset between edges and check everything clears at once
  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_peak", 32'(peakLevel), 0);
    chk("rst_leds", 32'(meterLeds), 0);
    chk("rst_clip", 32'(clip), 0);
`ifdef LEVEL_METER_CLIPCOUNT_EN
    chk("rst_cnt", 32'(clipCount), 0);
`endif
    reset   = 1'b0;
    meterIn = 16'd0;
  endtask

  // Bar-graph reference from the dBFS threshold list
  function automatic logic [7:0] thermo(input int p);
    int t[8] = '{260, 519, 1036, 2068, 4125, 8231, 16423, 29204};
    thermo = '0;
    for (int i = 0; i < 8; i++) thermo[i] = (p >= t[i]);
  endfunction

  initial begin
    int exp_pk, prev_pk;

    // Reset held for 3 edges with a large input present
    reset   = 1'b1;
    meterIn = 16'sd20000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_48);
      #1;
      chk("inrst_peak", 32'(peakLevel), 0);
      chk("inrst_leds", 32'(meterLeds), 0);
      chk("inrst_clip", 32'(clip), 0);
    end
    reset = 1'b0;
    step(16'd20000);
    chk("first_capture", 32'(peakLevel), 20000);
    chk("first_leds_lag", 32'(meterLeds), 0);
    step(16'd20000);
    chk("first_leds", 32'(meterLeds), 32'h7F);

    // Hold for capture edge + 8 hold edges, then decay by 1000 to 0
    do_reset();
    step(16'd16423);
    chk("hd_capture", 32'(peakLevel), 16423);
    for (int i = 0; i < 8; i++) begin
      step(16'd0);
      chk("hd_hold", 32'(peakLevel), 16423);
      chk("hd_hold_leds", 32'(meterLeds), 32'h7F);
    end
    prev_pk = 16423;
    for (int k = 1; k <= 17; k++) begin
      step(16'd0);
      exp_pk = 16423 - 1000 * k;
      if (exp_pk < 0) exp_pk = 0;
      chk("hd_decay", 32'(peakLevel), 32'(exp_pk));
      chk("hd_decay_leds", 32'(meterLeds), 32'(thermo(prev_pk)));
      prev_pk = exp_pk;
    end
    step(16'd0);
    chk("hd_idle_peak", 32'(peakLevel), 0);
    chk("hd_idle_leds", 32'(meterLeds), 0);

    // Retrigger: larger sample restarts full hold, smaller one is ignored
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(16'd8000);
      chk("rt_8000", 32'(peakLevel), 8000);
    end
    step(16'd12000);
    chk("rt_12000", 32'(peakLevel), 12000);
    step(16'd5000);
    chk("rt_ignore", 32'(peakLevel), 12000);
    for (int i = 0; i < 7; i++) begin
      step(16'd0);
      chk("rt_hold", 32'(peakLevel), 12000);
    end
    step(16'd0);
    chk("rt_decay", 32'(peakLevel), 11000);

    // Decay catch: peak 3000 in decay, constant 2500 input
    do_reset();
    step(16'd4000);
    for (int i = 0; i < 8; i++) step(16'd0);
    step(16'd0);
    chk("dc_3000", 32'(peakLevel), 3000);
    step(16'd2500);
    chk("dc_catch", 32'(peakLevel), 2500);
    step(16'd2500);
    chk("dc_recap", 32'(peakLevel), 2500);
    step(16'd0);
    chk("dc_inhold", 32'(peakLevel), 2500);

    // Single -32768: clip high through edges 0..3, drops on edge 4
    do_reset();
    step(16'h8000);
    chk("cl_peak", 32'(peakLevel), 32767);
    chk("cl_e0", 32'(clip), 1);
    step(16'd0);
    chk("cl_leds", 32'(meterLeds), 32'hFF);
    chk("cl_e1", 32'(clip), 1);
    step(16'd0);
    chk("cl_e2", 32'(clip), 1);
    step(16'd0);
    chk("cl_e3", 32'(clip), 1);
    step(16'd0);
    chk("cl_e4", 32'(clip), 0);

    // Clip retrigger on the third clip edge
    do_reset();
    step(16'h8000);
    step(16'd0);
    step(16'd32767);
    chk("cr_e2", 32'(clip), 1);
    for (int i = 3; i <= 5; i++) begin
      step(16'd0);
      chk("cr_hold", 32'(clip), 1);
    end
    step(16'd0);
    chk("cr_e6", 32'(clip), 0);

    // -32767 clips, 32766 does not
    do_reset();
    step(16'h8001);
    chk("cm_neg_clip", 32'(clip), 1);
    chk("cm_neg_peak", 32'(peakLevel), 32767);
    do_reset();
    step(16'd32766);
    chk("cm_noclip", 32'(clip), 0);
    chk("cm_noclip_pk", 32'(peakLevel), 32766);

`ifdef LEVEL_METER_CLIPCOUNT_EN
    // Clip event counter: isolated pulses, saturation, runs count once
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(16'd32767);
      step(16'd0);
    end
    chk("cc_3", 32'(clipCount), 3);
    for (int i = 0; i < 297; i++) begin
      step(16'd32767);
      step(16'd0);
    end
    chk("cc_sat", 32'(clipCount), 255);
    do_reset();
    for (int i = 0; i < 10; i++) step(16'd32767);
    step(16'd0);
    chk("cc_run", 32'(clipCount), 1);
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
